// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, loader FSM state encoding and
// the default instruction-memory depth.
package cpu_pkg;

  localparam int DEFAULT_DEPTH = 16;

  // Opcodes live in instruction bits [15:13].
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HI    = 3'd1;
  localparam logic [2:0] ST_LO    = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_FILL  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/imem_ram.sv
// Writable instruction RAM: synchronous write from the loader, asynchronous
// read for the CPU fetch path addressed by the byte-granular pc.
module imem_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W:0]   pc,
  output logic [15:0]       instr
);

  logic [15:0] mem [DEPTH];
  logic        unused_pc_lsb;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Words are 16 bits wide, so pc[0] never selects anything.
  assign instr         = mem[pc[ADDR_W:1]];
  assign unused_pc_lsb = pc[0];

endmodule

// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction memory, zero-filling the
// rest of the image after a hlt word, while holding the CPU off via busy.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [7:0]        hi_reg, hi_next;
  logic [7:0]        lo_reg, lo_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cnt_next   = '0;
            state_next = ST_HI;
          end
        end
        ST_HI: begin
          if (in_valid) begin
            hi_next    = in_data;
            state_next = ST_LO;
          end
        end
        ST_LO: begin
          if (in_valid) begin
            lo_next    = in_data;
            state_next = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The last slot ends the image even if it is not a hlt.
          if (cnt_reg == LAST_ADDR) begin
            state_next = ST_DONE;
          end else begin
            cnt_next   = cnt_reg + ADDR_W'(1);
            state_next = (hi_reg[7:5] == OP_HLT) ? ST_FILL : ST_HI;
          end
        end
        ST_FILL: begin
          if (cnt_reg == LAST_ADDR) begin
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg + ADDR_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign in_ready  = (state_reg == ST_HI) || (state_reg == ST_LO);
  assign mem_we    = (state_reg == ST_WRITE) || (state_reg == ST_FILL);
  assign mem_addr  = mem_we ? cnt_reg : '0;
  assign mem_wdata = (state_reg == ST_WRITE) ? {hi_reg, lo_reg} : 16'h0000;
  assign busy      = (state_reg == ST_HI) || (state_reg == ST_LO) ||
                     (state_reg == ST_WRITE) || (state_reg == ST_FILL);
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with an imem_ram alongside it; expected
// memory writes and the final image come from a byte-stream model.
module tb_imem_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    bit          hlt;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [4:0]  pc;
  logic [15:0] instr;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          hlt_cyc = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;

  wr_t         exp_q[$];
  logic [15:0] exp_img[16];
  logic [7:0]  stim_q[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we(mem_we), .waddr(mem_addr), .wdata(mem_wdata),
    .pc(pc), .instr(instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle: each memory write must be the next one the model predicts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h, required no write", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          $display("[TB] write addr %0d data %h (expected %0d %h)", mem_addr, mem_wdata, e.addr, e.data);
          check("write_addr", 32'(mem_addr), 32'(e.addr));
          check("write_data", 32'(mem_wdata), 32'(e.data));
          if (e.hlt) hlt_cyc = cyc;
          last_wr_cyc = cyc;
        end
        check("busy_in_write", 32'(busy), 32'd1);
        check("ready_in_write", 32'(in_ready), 32'd0);
      end else begin
        check("idle_addr", 32'(mem_addr), 32'd0);
        check("idle_wdata", 32'(mem_wdata), 32'd0);
      end
      check("done_busy_excl", 32'(done & busy), 32'd0);
    end
  end

  // Image rule: words in order until a hlt (rest zero) or the memory is full.
  task automatic load_model();
    int nw;
    wr_t e;
    nw = stim_q.size() / 2;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= nw) break;
      e.data = {stim_q[2*i], stim_q[2*i+1]};
      e.addr = 4'(i);
      e.hlt  = (e.data[15:13] == 3'b111);
      exp_q.push_back(e);
      exp_img[i] = e.data;
      if (e.hlt && i < DEPTH - 1) begin
        for (int j = i + 1; j < DEPTH; j++) begin
          e.addr = 4'(j);
          e.data = 16'h0000;
          e.hlt  = 1'b0;
          exp_q.push_back(e);
          exp_img[j] = 16'h0000;
        end
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Valid/ready source; start is also raised at byte start_idx to prove it is ignored.
  task automatic send_bytes(input bit toggle, input int start_idx);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (idx < stim_q.size() && guard < 400) begin
      @(negedge clk);
      guard++;
      in_data  = stim_q[idx];
      in_valid = toggle ? ph : 1'b1;
      ph       = ~ph;
      start    = (idx == start_idx);
      if (in_valid && in_ready) idx++;
    end
    if (guard >= 400) check("send_timeout", 32'(idx), 32'(stim_q.size()));
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("done_reached", 32'(done), 32'd1);
    done_cyc = cyc;
  endtask

  task automatic check_image(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      pc = {4'(a), 1'b0};
      #1;
      check(name, 32'(instr), 32'(exp_img[a]));
    end
  endtask

  task automatic read_word(input int a, input logic [15:0] exp);
    pc = {4'(a), 1'b1};
    #1;
    check("literal_word", 32'(instr), 32'(exp));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, 32'(in_ready), 32'd0);
    check({name, "_we"},    32'(mem_we),   32'd0);
    check({name, "_addr"},  32'(mem_addr), 32'd0);
    check({name, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({name, "_busy"},  32'(busy),     32'd0);
    check({name, "_done"},  32'(done),     32'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; pc = '0;

    // Reset, then idle with bytes offered: nothing consumed, nothing started.
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // hlt at word 2: zero fill 3..15, DONE DEPTH-2 = 14 cycles after its write.
    $display("[TB] session: hlt at word 2");
    stim_q = '{8'h20, 8'h84, 8'h21, 8'h06, 8'hE0, 8'h00};
    load_model();
    pulse_start();
    send_bytes(1'b0, -1);
    wait_done();
    check("hlt_to_done", 32'(done_cyc - hlt_cyc), 32'd14);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check_image("image_s1");
    read_word(0, 16'h2084); read_word(1, 16'h2106); read_word(2, 16'hE000);
    read_word(3, 16'h0000); read_word(15, 16'h0000);
    repeat (4) @(negedge clk);
    check("done_held", 32'(done), 32'd1);

    // Sixteen words, no hlt: fills the memory exactly, DONE right after the last write.
    $display("[TB] session: full image, no hlt");
    stim_q.delete();
    for (int i = 1; i <= 16; i++) begin
      stim_q.push_back(8'h00);
      stim_q.push_back(8'(i));
    end
    load_model();
    pulse_start();
    send_bytes(1'b0, -1);
    wait_done();
    check("last_write_to_done", 32'(done_cyc - last_wr_cyc), 32'd1);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check_image("image_s2");
    read_word(0, 16'h0001); read_word(15, 16'h0010);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    check("done_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // in_valid toggling, and a start pulse mid-session that must be ignored.
    $display("[TB] session: toggling valid, start while busy");
    stim_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hE0, 8'h00};
    load_model();
    pulse_start();
    send_bytes(1'b1, 3);
    wait_done();
    check("hlt_to_done_s3", 32'(done_cyc - hlt_cyc), 32'd14);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check_image("image_s3");
    read_word(1, 16'hABCD);

    // Abort after the high byte of word 2: words 0..1 written, word 2 keeps old E000.
    $display("[TB] session: abort after high byte of word 2");
    stim_q = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33};
    load_model();
    exp_img[2] = 16'hE000;
    pulse_start();
    send_bytes(1'b0, -1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check_image("image_abort");
    read_word(2, 16'hE000);
    stim_q = '{8'h40, 8'h01, 8'hE0, 8'h00};
    load_model();
    pulse_start();
    send_bytes(1'b0, -1);
    wait_done();
    check("hlt_to_done_s4", 32'(done_cyc - hlt_cyc), 32'd15);
    check_image("image_reload");

    // Reset mid-FILL: outputs drop without a clock edge, no writes afterwards.
    $display("[TB] session: reset during fill");
    stim_q = '{8'hE0, 8'h00};
    load_model();
    pulse_start();
    send_bytes(1'b0, -1);
    repeat (4) @(negedge clk);
    check("in_fill_we", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'hE0;
    repeat (20) @(negedge clk);
    in_valid = 1'b0;
    check("post_reset_busy", 32'(busy), 32'd0);

    // start and abort together from DONE: abort wins.
    $display("[TB] session: start+abort from DONE");
    stim_q = '{8'hE0, 8'h00};
    load_model();
    pulse_start();
    send_bytes(1'b0, -1);
    wait_done();
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_done", 32'(done), 32'd0);
    check("sa_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("sa_stays_idle", 32'(busy | done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
